// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_M masters, with a
// watchdog that aborts a cycle whose STB waits too long and flags ERR.
module wishbone_rr_arbiter_slot #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int SW = 3
) (
  input  logic          en,
  input  logic          abort,
  input  logic          cyc,
  input  logic          stb,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] dat,
  input  logic [SW-1:0] sel,
  input  logic          s_ack,
  output logic          fwd_cyc,
  output logic          fwd_stb,
  output logic          fwd_we,
  output logic [AW-1:0] fwd_adr,
  output logic [DW-1:0] fwd_dat,
  output logic [SW-1:0] fwd_sel,
  output logic          ack,
  output logic          err
);
  // Fields are zeroed unless this master holds the bus, so the top can OR-merge.
  assign fwd_cyc = en & cyc;
  assign fwd_stb = en & cyc & stb;
  assign fwd_we  = en & we;
  assign fwd_adr = en ? adr : '0;
  assign fwd_dat = en ? dat : '0;
  assign fwd_sel = en ? sel : '0;
  assign ack     = fwd_stb & s_ack;
  assign err     = abort;
endmodule

module wishbone_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int SW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NUM_M-1:0]    M_CYC_I,
  input  logic [NUM_M-1:0]    M_STB_I,
  input  logic [NUM_M-1:0]    M_WE_I,
  input  logic [NUM_M*AW-1:0] M_ADR_I,
  input  logic [NUM_M*DW-1:0] M_DATA_I,
  input  logic [NUM_M*SW-1:0] M_SEL_I,
  output logic [DW-1:0]       M_DATA_O,
  output logic [NUM_M-1:0]    M_ACK_O,
  output logic [NUM_M-1:0]    M_ERR_O,
  output logic                S_CYC_O,
  output logic                S_STB_O,
  output logic                S_WE_O,
  output logic [AW-1:0]       S_ADR_O,
  output logic [DW-1:0]       S_DATA_O,
  output logic [SW-1:0]       S_SEL_O,
  input  logic [DW-1:0]       S_DATA_I,
  input  logic                S_ACK_I,
  output logic [NUM_M-1:0]    GNT_O
);
  localparam int LW = $clog2(NUM_M);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } req_t;

  state_t                   state, state_nxt;
  logic [NUM_M-1:0]         gnt, gnt_nxt;
  logic [LW-1:0]            last, last_nxt, owner, pick;
  logic [CW-1:0]            wd, wd_nxt;
  logic                     found;
  int                       idx;
  logic                     busy, aborting;
  logic [NUM_M-1:0]         fwd_cyc, fwd_stb, fwd_we;
  logic [NUM_M-1:0][AW-1:0] fwd_adr;
  logic [NUM_M-1:0][DW-1:0] fwd_dat;
  logic [NUM_M-1:0][SW-1:0] fwd_sel;
  req_t                     req;

  assign busy     = (state == BUSY);
  assign aborting = (state == ABORT);

  for (genvar i = 0; i < NUM_M; i++) begin : g_slot
    wishbone_rr_arbiter_slot #(.DW(DW), .AW(AW), .SW(SW)) u_slot (
      .en      (gnt[i] & busy),
      .abort   (gnt[i] & aborting),
      .cyc     (M_CYC_I[i]),
      .stb     (M_STB_I[i]),
      .we      (M_WE_I[i]),
      .adr     (M_ADR_I[i*AW +: AW]),
      .dat     (M_DATA_I[i*DW +: DW]),
      .sel     (M_SEL_I[i*SW +: SW]),
      .s_ack   (S_ACK_I),
      .fwd_cyc (fwd_cyc[i]),
      .fwd_stb (fwd_stb[i]),
      .fwd_we  (fwd_we[i]),
      .fwd_adr (fwd_adr[i]),
      .fwd_dat (fwd_dat[i]),
      .fwd_sel (fwd_sel[i]),
      .ack     (M_ACK_O[i]),
      .err     (M_ERR_O[i])
    );
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_M; i++) begin
      req.cyc = req.cyc | fwd_cyc[i];
      req.stb = req.stb | fwd_stb[i];
      req.we  = req.we  | fwd_we[i];
      req.adr = req.adr | fwd_adr[i];
      req.dat = req.dat | fwd_dat[i];
      req.sel = req.sel | fwd_sel[i];
    end
  end

  assign S_CYC_O  = req.cyc;
  assign S_STB_O  = req.stb;
  assign S_WE_O   = req.we;
  assign S_ADR_O  = req.adr;
  assign S_DATA_O = req.dat;
  assign S_SEL_O  = req.sel;
  assign M_DATA_O = S_DATA_I;
  assign GNT_O    = gnt;

  // First requester after the last holder, wrapping past NUM_M-1.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last) + k) % NUM_M;
      if (!found && M_CYC_I[LW'(idx)]) begin
        found = 1'b1;
        pick  = LW'(idx);
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_M; i++)
      if (gnt[i]) owner = LW'(i);
  end

  // The ABORT cycle itself is the TIMEOUT-th wait cycle, so BUSY leaves
  // after TIMEOUT-1 consecutive STB-without-ACK cycles.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    wd_nxt    = wd;
    unique case (state)
      IDLE: begin
        wd_nxt = '0;
        if (|M_CYC_I) begin
          gnt_nxt   = NUM_M'(1) << pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req.cyc) begin
          last_nxt  = owner;
          gnt_nxt   = '0;
          wd_nxt    = '0;
          state_nxt = IDLE;
        end else if (req.stb && !S_ACK_I) begin
          if (wd == CW'(TIMEOUT - 2)) state_nxt = ABORT;
          else                        wd_nxt    = wd + CW'(1);
        end else begin
          wd_nxt = '0;
        end
      end
      ABORT: begin
        last_nxt  = owner;
        gnt_nxt   = '0;
        wd_nxt    = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= LW'(NUM_M - 1);
      wd    <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      wd    <= wd_nxt;
    end
  end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: per-cycle reference model compare plus
// directed scenarios with literal expectations and a randomized soak.
module tb_wishbone_rr_arbiter;
  localparam int N = 4, DW = 8, AW = 8, SW = 3, TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      cyc, stb, we;
  logic [N*AW-1:0]   adr;
  logic [N*DW-1:0]   wdat;
  logic [N*SW-1:0]   sel;
  logic [DW-1:0]     mdat, sdat_o, sdat_i;
  logic [N-1:0]      ack, err, gnt;
  logic              scyc, sstb, swe, sack;
  logic [AW-1:0]     sadr;
  logic [SW-1:0]     ssel;

  int tests = 0, fails = 0;
  bit en_cmp = 1'b0;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.NUM_M(N), .DW(DW), .AW(AW), .SW(SW), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M_CYC_I(cyc), .M_STB_I(stb), .M_WE_I(we),
    .M_ADR_I(adr), .M_DATA_I(wdat), .M_SEL_I(sel),
    .M_DATA_O(mdat), .M_ACK_O(ack), .M_ERR_O(err),
    .S_CYC_O(scyc), .S_STB_O(sstb), .S_WE_O(swe),
    .S_ADR_O(sadr), .S_DATA_O(sdat_o), .S_SEL_O(ssel),
    .S_DATA_I(sdat_i), .S_ACK_I(sack), .GNT_O(gnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether it is in its abort cycle,
  // the previous owner and how many consecutive unanswered STB cycles.
  int owner = -1, last = N - 1, wcnt = 0;
  bit abrt = 1'b0;
  logic [N-1:0] e_ack, e_err, e_gnt;
  logic         e_cyc, e_stb;
  int           cand, pickm;

  always @(negedge clk) begin
    e_gnt = (owner >= 0) ? (N'(1) << owner) : '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_ack = '0; e_err = '0;
    if (owner >= 0 && !abrt) begin
      e_cyc = cyc[owner];
      e_stb = cyc[owner] & stb[owner];
      e_ack[owner] = sack & e_stb;
    end
    if (owner >= 0 && abrt) e_err[owner] = 1'b1;
    if (en_cmp) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("s_cyc", 32'(scyc), 32'(e_cyc));
      chk("s_stb", 32'(sstb), 32'(e_stb));
      chk("m_ack", 32'(ack), 32'(e_ack));
      chk("m_err", 32'(err), 32'(e_err));
      chk("m_data", 32'(mdat), 32'(sdat_i));
      if (e_stb) begin
        chk("s_adr", 32'(sadr), 32'(adr[owner*AW +: AW]));
        chk("s_dat", 32'(sdat_o), 32'(wdat[owner*DW +: DW]));
        chk("s_sel", 32'(ssel), 32'(sel[owner*SW +: SW]));
        chk("s_we", 32'(swe), 32'(we[owner]));
      end
    end
    if (rst) begin
      owner = -1; last = N - 1; wcnt = 0; abrt = 1'b0;
    end else if (owner < 0) begin
      pickm = -1;
      for (int k = 1; k <= N; k++) begin
        cand = (last + k) % N;
        if (pickm < 0 && cyc[cand]) pickm = cand;
      end
      owner = pickm; wcnt = 0;
    end else if (abrt) begin
      last = owner; owner = -1; abrt = 1'b0; wcnt = 0;
    end else if (!cyc[owner]) begin
      last = owner; owner = -1; wcnt = 0;
    end else if (e_stb && !sack) begin
      wcnt++;
      if (wcnt == TO - 1) abrt = 1'b1;
    end else begin
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = '0; stb = '0; sack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [DW-1:0] burst [3] = '{8'h11, 8'h22, 8'h33};
  int            seq[$];
  int            n, mode;
  bit            seen;
  logic [N-1:0]  acked, prev_gnt;

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
    sack = 1'b0; sdat_i = '0;
    tick(); tick();
    en_cmp = 1'b1;

    // Single write from master 0.
    do_reset();
    #2 chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_scyc", 32'(scyc), 32'h0);
    tick();
    cyc = 4'b0001; stb = 4'b0001; we = 4'b0001;
    adr[7:0] = 8'h10; wdat[7:0] = 8'hA5; sel[2:0] = 3'b111;
    #2 chk("t1_gnt_pre", 32'(gnt), 32'h0);
    tick();
    #2 chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_adr", 32'(sadr), 32'h10);
    chk("t1_dat", 32'(sdat_o), 32'hA5);
    chk("t1_ack_wait", 32'(ack), 32'h0);
    sack = 1'b1;
    #1 chk("t1_ack", 32'(ack), 32'h1);
    tick();
    cyc = '0; stb = '0; sack = 1'b0;
    tick();
    #2 chk("t1_idle", 32'(gnt), 32'h0);

    // ACK from slave while idle is not forwarded.
    sack = 1'b1;
    #1 chk("t6_ack_idle", 32'(ack), 32'h0);
    tick();
    #2 chk("t6_ack_idle2", 32'(ack), 32'h0);
    sack = 1'b0;

    // All masters request; each drops CYC for a cycle after its beat.
    do_reset();
    we = '0; sack = 1'b1; acked = '0; prev_gnt = '0; seq = {};
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      cyc = ~acked; stb = ~acked;
      #2;
      acked = ack;
      if (gnt != '0 && prev_gnt == '0) seq.push_back(onehot_idx(gnt));
      prev_gnt = gnt;
      tick();
    end
    chk("t2_seq_len", 32'(seq.size()), 32'd5);
    for (int k = 0; k < seq.size() && k < 5; k++)
      chk("t2_seq", 32'(seq[k]), 32'(k % 4));
    cyc = '0; stb = '0; sack = 1'b0;

    // Master 2 read burst while 1 and 3 wait.
    do_reset();
    cyc = 4'b0100; stb = '0; we = '0;
    tick();
    cyc = 4'b1110; stb = 4'b0100; sack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      sdat_i = burst[b];
      #2 chk("t3_data", 32'(mdat), 32'(burst[b]));
      chk("t3_ack", 32'(ack), 32'h4);
      chk("t3_gnt", 32'(gnt), 32'h4);
      tick();
    end
    cyc = 4'b1010; stb = '0; sack = 1'b0;
    tick();
    #2 chk("t3_idle", 32'(gnt), 32'h0);
    tick();
    #2 chk("t3_next", 32'(gnt), 32'h8);
    cyc = '0;
    tick(); tick();

    // Watchdog: master 1 stalls, master 3 waits.
    do_reset();
    cyc = 4'b1010; stb = 4'b0010; sack = 1'b0;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      #2;
      if (gnt != '0) n++;
      if (err != '0) begin
        seen = 1'b1;
        chk("t4_err", 32'(err), 32'h2);
        chk("t4_scyc", 32'(scyc), 32'h0);
        chk("t4_ack", 32'(ack), 32'h0);
      end
    end
    chk("t4_seen", 32'(seen), 32'h1);
    chk("t4_cycles", 32'(n), 32'd16);
    tick();
    cyc = 4'b1000; stb = '0;
    #2 chk("t4_idle", 32'(gnt), 32'h0);
    chk("t4_err_once", 32'(err), 32'h0);
    tick();
    #2 chk("t4_next", 32'(gnt), 32'h8);
    cyc = '0;
    tick(); tick();

    // Reset in the middle of master 2's burst.
    do_reset();
    cyc = 4'b0100;
    tick();
    cyc = 4'b0101; stb = 4'b0100; sack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    #2 chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_scyc", 32'(scyc), 32'h0);
    chk("t5_ack", 32'(ack), 32'h0);
    rst = 1'b0;
    tick();
    #2 chk("t5_prio", 32'(gnt), 32'h1);
    cyc = '0; stb = '0; sack = 1'b0;
    tick(); tick();

    // Randomized soak, the model compare runs every cycle.
    for (int c = 0; c < 4500; c++) begin
      mode = (c / 500) % 3;
      for (int i = 0; i < N; i++) begin
        if (!cyc[i]) cyc[i] = ($urandom_range(0, 3) == 0);
        else if (err[i] || (mode == 1 ? ($urandom_range(0, 63) == 0)
                                      : ($urandom_range(0, 4) == 0))) cyc[i] = 1'b0;
        stb[i] = cyc[i] & ((mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      we     = N'($urandom);
      adr    = (N*AW)'($urandom);
      wdat   = (N*DW)'($urandom);
      sel    = (N*SW)'($urandom);
      sdat_i = DW'($urandom);
      sack   = (mode == 0) ? 1'($urandom_range(0, 1))
             : (mode == 1) ? ($urandom_range(0, 39) == 0) : 1'b1;
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
